// File: rtl/rvc_pkg.sv
// Shared RV32IC fetch/decode types: halfword type, canonical NOP and RVC length test.
package rvc_pkg;

    typedef logic [15:0] hw_t;

    localparam logic [31:0] RVC_NOP = 32'h0000_0013;

    function automatic logic is_rvc(input hw_t hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/rvc_hw_ring.sv
// Halfword ring for the realign buffer: multi-halfword push, two-entry read window.
module rvc_hw_ring
    import rvc_pkg::*;
#(
    parameter int FETCH_BYTES = 4,
    parameter int BUF_HW      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              push,
    input  logic [$clog2(FETCH_BYTES)-2:0]    push_skip,
    input  logic [8*FETCH_BYTES-1:0]          push_data,
    input  logic                              pop,
    input  logic                              pop_two,
    output hw_t                               rd_h0,
    output hw_t                               rd_h1,
    output logic [$clog2(BUF_HW+1)-1:0]       count
);

    localparam int NHW = FETCH_BYTES / 2;
    localparam int PW  = $clog2(BUF_HW);
    localparam int CW  = $clog2(BUF_HW + 1);

    hw_t            mem_q [BUF_HW];
    hw_t            mem_d [BUF_HW];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  n_push, n_pop;

    always_comb begin
        n_push   = push ? CW'(NHW - int'(push_skip)) : '0;
        n_pop    = pop ? (pop_two ? CW'(2) : CW'(1)) : '0;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q + PW'(n_pop);
        wr_ptr_d = wr_ptr_q + PW'(n_push);
        count_d  = count_q + n_push - n_pop;
        // Halfwords below the entry offset belong to the previous stream.
        for (int i = 0; i < NHW; i++) begin
            if (push && i >= int'(push_skip)) begin
                mem_d[wr_ptr_q + PW'(i - int'(push_skip))] = push_data[16*i +: 16];
            end
        end
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_h0 = mem_q[rd_ptr_q];
    assign rd_h1 = mem_q[rd_ptr_q + PW'(1)];
    assign count = count_q;

endmodule

// File: rtl/rvc_realign_buffer.sv
// Fetch-to-decode realign buffer: issues one whole RVC or 32-bit instruction per handshake.
module rvc_realign_buffer
    import rvc_pkg::*;
#(
    parameter int FETCH_BYTES = 4,
    parameter int BUF_HW      = 4,
    parameter int XLEN        = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      fetch_valid,
    output logic                      fetch_ready,
    input  logic [XLEN-1:0]           fetch_pc,
    input  logic [8*FETCH_BYTES-1:0]  fetch_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_inst,
    output logic [XLEN-1:0]           out_pc,
    output logic                      out_is_rvc
);

    localparam int NHW = FETCH_BYTES / 2;
    localparam int CW  = $clog2(BUF_HW + 1);
    localparam int SW  = $clog2(FETCH_BYTES) - 1;

    logic [CW-1:0]    count;
    logic [CW-1:0]    count_after_pop;
    hw_t              h0, h1;
    logic             rvc, push, pop;
    logic [SW-1:0]    skip;
    logic [XLEN-1:0]  head_pc_q, head_pc_d;

    assign skip = fetch_pc[$clog2(FETCH_BYTES)-1:1];

    rvc_hw_ring #(
        .FETCH_BYTES (FETCH_BYTES),
        .BUF_HW      (BUF_HW)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_skip (skip),
        .push_data (fetch_data),
        .pop       (pop),
        .pop_two   (!rvc),
        .rd_h0     (h0),
        .rd_h1     (h1),
        .count     (count)
    );

    // Registered count only, so no combinational path from out_ready.
    assign fetch_ready = (count <= CW'(BUF_HW - NHW));
    assign rvc         = is_rvc(h0);
    assign out_valid   = rvc ? (count >= CW'(1)) : (count >= CW'(2));
    assign out_inst    = !out_valid ? RVC_NOP : (rvc ? {16'h0, h0} : {h1, h0});
    assign out_pc      = head_pc_q;
    assign out_is_rvc  = out_valid & rvc;
    assign push        = fetch_valid & fetch_ready & !flush;
    assign pop         = out_valid & out_ready & !flush;

    always_comb begin
        count_after_pop = count - (pop ? (rvc ? CW'(1) : CW'(2)) : CW'(0));
        head_pc_d       = head_pc_q;
        if (pop) begin
            head_pc_d = head_pc_q + (rvc ? XLEN'(2) : XLEN'(4));
        end
        if (push && count_after_pop == '0) begin
            head_pc_d = fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_pc_q <= '0;
        end else begin
            head_pc_q <= head_pc_d;
        end
    end

endmodule
